tt_um_ram_loader: RTL and testbench
===================================

Name: tt_um_ram_loader

Overview:
Upstream loader for the 16-byte DFF RAM. It accepts a byte stream over a valid/ready handshake and writes it into consecutive RAM addresses starting at 0, then hands the RAM port back to the CPU. It keeps an 8-bit additive checksum of the loaded bytes. When the loader is not active, it muxes the CPU's MAR/data/control straight through to the RAM.

Parameters:
RAM_BYTES, 16, number of bytes loaded per session (last address = RAM_BYTES-1)
ADDR_BITS, 4, width of RAM address; 2**ADDR_BITS >= RAM_BYTES

Ports:
clk  input  1  clock
rst_n  input  1  synchronous active-low reset
ena  input  1  Tiny Tapeout enable; when low, all state holds
start  input  1  begin load session (sampled in IDLE or DONE)
abort  input  1  cancel session in LOAD
in_valid  input  1  stream byte valid
in_data  input  8  stream byte
in_ready  output  1  loader accepts a byte this cycle
cpu_mar  input  ADDR_BITS  CPU address, passed through when idle
cpu_data  input  8  CPU write data, passed through when idle
cpu_lr_n  input  1  CPU active-low load-RAM, passed through when idle
cpu_ce_n  input  1  CPU active-low chip enable, passed through when idle
ram_mar  output  ADDR_BITS  to RAM mar
ram_data  output  8  to RAM data_in
ram_lr_n  output  1  to RAM lr_n
ram_ce_n  output  1  to RAM ce_n
busy  output  1  high in LOAD or FLUSH
done  output  1  high in DONE
checksum  output  8  sum mod 256 of accepted bytes

Behaviour:
- Reset (rst_n=0 at posedge): state=IDLE, addr_cnt=0, checksum=0, wr_pend=0, wr_addr_q=0, wr_data_q=0. Reset mid-session drops any pending write; RAM mux returns to the CPU on the next cycle.
- ena=0: no register updates, in_ready=0, the RAM mux keeps its current selection.
- States: IDLE, LOAD, FLUSH, DONE.
- IDLE/DONE + start: go to LOAD; addr_cnt=0, checksum=0. start is ignored in LOAD and FLUSH.
- in_ready = ena && state==LOAD && !abort (combinational).
- Handshake: in_valid && in_ready at a posedge accepts the byte:
  - wr_addr_q <= addr_cnt, wr_data_q <= in_data, wr_pend <= 1
  - checksum <= checksum + in_data (mod 256)
  - addr_cnt++
- wr_pend clears at the next posedge unless another byte is accepted there. Back-to-back acceptance gives one RAM write per cycle.
- The byte accepted when addr_cnt==RAM_BYTES-1 moves LOAD to FLUSH. FLUSH lasts one cycle so the final pending write is presented, then moves to DONE. No wrap-around: exactly RAM_BYTES writes per session.
- abort in LOAD: go to IDLE, accept no byte that cycle. A write already pending completes; done stays 0 and checksum holds its partial value.
- RAM mux:
  - Loader owns the port when state is LOAD or FLUSH, or wr_pend=1. Then ram_mar=wr_addr_q, ram_data=wr_data_q, ram_lr_n=~wr_pend, ram_ce_n=1.
  - Otherwise all four ram_* outputs equal the cpu_* inputs (combinational).
- Latency: a byte accepted at edge k is written by the RAM at edge k+1.
- busy/done/checksum are decoded from registered state; done holds until start or reset.

Test Plan:
- Reset, idle mux: cpu_mar=5, cpu_ce_n=0, cpu_lr_n=1 -> ram_mar=5, ram_ce_n=0, ram_lr_n=1, busy=0, done=0, checksum=0.
- Full load back-to-back: start, then 16 bytes 0x10..0x1F with in_valid held high -> 16 consecutive cycles with ram_lr_n=0 at addr 0..15. FLUSH then DONE, done=1, checksum=0x78. CPU readback of addr 7 returns 0x17.
- Throttled source: in_valid toggles every other cycle with bytes 0xFF x16 -> ram_lr_n=0 only in cycles after an accept, addresses are sequential, checksum=0xF0.
- Abort: abort after 3 bytes (1,2,3) -> third write completes, state=IDLE, done=0, checksum=0x06, mux back to CPU; addr 3 is unchanged.
- ena gating: drop ena for 5 cycles mid-load with in_valid=1 -> in_ready=0, no writes, addr_cnt held. Resume completes all 16 bytes correctly.
- Reset mid-load: rst_n=0 for one cycle right after an accept -> no RAM write on the following cycle, state=IDLE, checksum=0.

Source files
------------

// File: rtl/tt_um_ram_loader.sv
// Byte-stream loader for the 16-byte DFF RAM.
// Accepts bytes over a valid/ready handshake and writes them to consecutive
// RAM addresses from 0, keeping an 8-bit additive checksum. While no session
// is in progress the CPU's MAR/data/control pass straight through to the RAM.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   ena                 global enable; when low all state holds
//   start, abort        begin a session / cancel a session in progress
//   in_valid, in_data   byte stream input; in_ready accepts it
//   cpu_*               CPU-side RAM controls, forwarded when the loader is idle
//   ram_*               RAM port (mar, data_in, lr_n, ce_n)
//   busy, done          session in progress / session finished
//   checksum            sum mod 256 of the bytes accepted this session
module tt_um_ram_loader #(
  parameter int unsigned RAM_BYTES = 16,
  parameter int unsigned ADDR_BITS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ena,
  input  logic                 start,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  input  logic [ADDR_BITS-1:0] cpu_mar,
  input  logic [7:0]           cpu_data,
  input  logic                 cpu_lr_n,
  input  logic                 cpu_ce_n,
  output logic [ADDR_BITS-1:0] ram_mar,
  output logic [7:0]           ram_data,
  output logic                 ram_lr_n,
  output logic                 ram_ce_n,
  output logic                 busy,
  output logic                 done,
  output logic [7:0]           checksum
);

  typedef enum logic [1:0] {StIdle, StLoad, StFlush, StDone} state_e;

  localparam logic [ADDR_BITS-1:0] LastAddr = ADDR_BITS'(RAM_BYTES - 1);

  state_e                 state_q, state_d;
  logic [ADDR_BITS-1:0]   addr_cnt_q, addr_cnt_d;
  logic [7:0]             checksum_q, checksum_d;
  logic                   wr_pend_q, wr_pend_d;
  logic [ADDR_BITS-1:0]   wr_addr_q, wr_addr_d;
  logic [7:0]             wr_data_q, wr_data_d;
  logic                   accept;
  logic                   loader_owns;

  assign in_ready = ena && (state_q == StLoad) && !abort;
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d    = state_q;
    addr_cnt_d = addr_cnt_q;
    checksum_d = checksum_q;
    wr_pend_d  = wr_pend_q;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    if (ena) begin
      // A pending write lasts exactly one enabled cycle unless refilled.
      wr_pend_d = accept;
      if (accept) begin
        wr_addr_d  = addr_cnt_q;
        wr_data_d  = in_data;
        checksum_d = checksum_q + in_data;
        addr_cnt_d = addr_cnt_q + 1'b1;
      end

      unique case (state_q)
        StIdle, StDone: begin
          if (start) begin
            state_d    = StLoad;
            addr_cnt_d = '0;
            checksum_d = '0;
          end
        end
        StLoad: begin
          if (abort) begin
            state_d = StIdle;
          end else if (accept && (addr_cnt_q == LastAddr)) begin
            state_d = StFlush;
          end
        end
        StFlush: state_d = StDone;
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      addr_cnt_q <= '0;
      checksum_q <= '0;
      wr_pend_q  <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
    end else begin
      state_q    <= state_d;
      addr_cnt_q <= addr_cnt_d;
      checksum_q <= checksum_d;
      wr_pend_q  <= wr_pend_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  // Keep the port after an abort until the last accepted byte is written.
  assign loader_owns = (state_q == StLoad) || (state_q == StFlush) || wr_pend_q;

  always_comb begin
    ram_mar  = cpu_mar;
    ram_data = cpu_data;
    ram_lr_n = cpu_lr_n;
    ram_ce_n = cpu_ce_n;
    if (loader_owns) begin
      ram_mar  = wr_addr_q;
      ram_data = wr_data_q;
      ram_lr_n = ~wr_pend_q;
      ram_ce_n = 1'b1;
    end
  end

  assign busy     = (state_q == StLoad) || (state_q == StFlush);
  assign done     = (state_q == StDone);
  assign checksum = checksum_q;

endmodule

// File: tb/tb_tt_um_ram_loader.sv
module tb_tt_um_ram_loader;

  logic       clk = 1'b0;
  logic       rst_n, ena, start, abort, in_valid, in_ready;
  logic [7:0] in_data;
  logic [3:0] cpu_mar, ram_mar;
  logic [7:0] cpu_data, ram_data;
  logic       cpu_lr_n, cpu_ce_n, ram_lr_n, ram_ce_n;
  logic       busy, done;
  logic [7:0] checksum;

  tt_um_ram_loader #(.RAM_BYTES(16), .ADDR_BITS(4)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .ena      (ena),
    .start    (start),
    .abort    (abort),
    .in_valid (in_valid),
    .in_data  (in_data),
    .in_ready (in_ready),
    .cpu_mar  (cpu_mar),
    .cpu_data (cpu_data),
    .cpu_lr_n (cpu_lr_n),
    .cpu_ce_n (cpu_ce_n),
    .ram_mar  (ram_mar),
    .ram_data (ram_data),
    .ram_lr_n (ram_lr_n),
    .ram_ce_n (ram_ce_n),
    .busy     (busy),
    .done     (done),
    .checksum (checksum)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // RAM model: writes on posedge when lr_n is low, frozen by reset or ena low.
  logic [7:0]  tb_ram [16];
  logic [31:0] act_q[$];
  logic [31:0] exp_q[$];
  int          cyc = 0;

  always @(posedge clk) begin
    if (rst_n && ena && (ram_lr_n == 1'b0)) begin
      tb_ram[ram_mar] <= ram_data;
      act_q.push_back({cyc[19:0], ram_mar, ram_data});
    end
    cyc <= cyc + 1;
  end

  // Reference model of a load session.
  logic       m_loading, m_flush, m_done, m_pend;
  int         m_cnt;
  logic [7:0] m_sum, m_pdata;
  logic [3:0] m_paddr;

  task automatic model_reset();
    m_loading = 1'b0; m_flush = 1'b0; m_done = 1'b0; m_pend = 1'b0;
    m_cnt = 0; m_sum = 8'h00; m_pdata = 8'h00; m_paddr = 4'h0;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, advance the model.
  task automatic step(input logic v, input logic [7:0] d, input logic en, input logic ab,
                      input logic st, input logic r);
    logic exp_ready, owns, acc;
    in_valid = v; in_data = d; ena = en; abort = ab; start = st; rst_n = r;
    @(negedge clk);
    exp_ready = en && m_loading && !ab;
    owns      = m_loading || m_flush || m_pend;
    chk("in_ready", in_ready, exp_ready);
    chk("busy", busy, m_loading || m_flush);
    chk("done", done, m_done);
    chk("checksum", checksum, m_sum);
    if (owns) begin
      chk("ram_lr_n_ld", ram_lr_n, !m_pend);
      chk("ram_ce_n_ld", ram_ce_n, 1'b1);
      if (m_pend) begin
        chk("ram_mar_ld", ram_mar, m_paddr);
        chk("ram_data_ld", ram_data, m_pdata);
      end
    end else begin
      chk("ram_mar_cpu", ram_mar, cpu_mar);
      chk("ram_data_cpu", ram_data, cpu_data);
      chk("ram_lr_n_cpu", ram_lr_n, cpu_lr_n);
      chk("ram_ce_n_cpu", ram_ce_n, cpu_ce_n);
    end
    if (r && en && m_pend) exp_q.push_back({cyc[19:0], m_paddr, m_pdata});
    acc = v && exp_ready;
    @(posedge clk);
    #1;
    if (!r) begin
      model_reset();
    end else if (en) begin
      m_pend = acc;
      if (acc) begin
        m_paddr = m_cnt[3:0];
        m_pdata = d;
        m_sum   = m_sum + d;
        m_cnt++;
      end
      if (m_flush) begin
        m_flush = 1'b0;
        m_done  = 1'b1;
      end else if (m_loading) begin
        if (ab) m_loading = 1'b0;
        else if (acc && m_cnt == 16) begin
          m_loading = 1'b0;
          m_flush   = 1'b1;
        end
      end else if (st) begin
        m_loading = 1'b1; m_done = 1'b0; m_cnt = 0; m_sum = 8'h00;
      end
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic compare_logs(input string tag);
    int n;
    chk({tag, "_wr_count"}, act_q.size(), exp_q.size());
    n = (act_q.size() < exp_q.size()) ? act_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) chk({tag, "_wr"}, act_q[i], exp_q[i]);
    act_q.delete();
    exp_q.delete();
  endtask

  logic [7:0] snap3;
  int         guard;

  initial begin
    rst_n = 1'b0; ena = 1'b1; start = 1'b0; abort = 1'b0; in_valid = 1'b0;
    in_data = 8'h00; cpu_mar = 4'd5; cpu_data = 8'hA5; cpu_lr_n = 1'b1; cpu_ce_n = 1'b0;
    for (int i = 0; i < 16; i++) tb_ram[i] = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    model_reset();

    // Reset state and idle pass-through.
    idle(2);
    chk("idle_mar5", ram_mar, 4'd5);
    chk("idle_ce_n", ram_ce_n, 1'b0);

    // Full back-to-back load 0x10..0x1F.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h10 + i), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("full_done", done, 1'b1);
    chk("full_sum", checksum, 8'h78);
    compare_logs("full");
    cpu_mar = 4'd7;
    idle(1);
    chk("readback7", tb_ram[7], 8'h17);

    // Throttled source, 0xFF bytes.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    guard = 0;
    while (m_loading && guard < 100) begin
      step(guard[0] == 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 1'b1);
      guard++;
    end
    idle(2);
    chk("thr_done", done, 1'b1);
    chk("thr_sum", checksum, 8'hF0);
    compare_logs("thr");

    // Abort after three bytes.
    snap3 = tb_ram[3];
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h44, 1'b1, 1'b1, 1'b0, 1'b1);
    idle(2);
    chk("abort_done", done, 1'b0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_sum", checksum, 8'h06);
    chk("abort_a2", tb_ram[2], 8'h03);
    chk("abort_a3", tb_ram[3], snap3);
    compare_logs("abort");

    // ena dropped for five cycles mid-load.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 5; i++) step(1'b1, 8'hEE, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int i = 6; i < 16; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b0, 1'b1);
    idle(2);
    chk("ena_done", done, 1'b1);
    chk("ena_sum", checksum, 8'h78);
    chk("ena_a15", tb_ram[15], 8'h0F);
    compare_logs("ena");

    // Randomized sessions.
    for (int s = 0; s < 6; s++) begin
      cpu_mar  = 4'($urandom);
      cpu_data = 8'($urandom);
      cpu_ce_n = 1'($urandom);
      step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
      guard = 0;
      while ((m_loading || m_flush) && guard < 300) begin
        step(($urandom % 3) != 0, 8'($urandom), ($urandom % 5) != 0,
             ($urandom % 80) == 0, ($urandom % 4) == 0, 1'b1);
        guard++;
      end
      chk("rnd_bounded", guard < 300, 1'b1);
      idle(2);
      compare_logs("rnd");
    end

    // Reset right after an accept drops the pending write.
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 1'b1);
    step(1'b1, 8'h5A, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b1, 8'h6B, 1'b1, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 1'b0);
    idle(2);
    chk("rst_busy", busy, 1'b0);
    chk("rst_sum", checksum, 8'h00);
    chk("rst_lr_n", ram_lr_n, 1'b1);
    compare_logs("rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
